arbiter_credit_round_robin_scheduler: RTL and testbench

//  Credit-based round-robin scheduler that shares one cache request path among N engine requesters.
//  - Sits between the per-requester input FIFOs and the cache request FIFO; outputs drive FIFO pops and the request mux select.
//  - Limits each requester's outstanding (unreturned) cache requests to MAX_CREDIT.
//  - Blocks all grants while downstream is not ready or the kernel descriptor is not valid.

---
 rtl/arbiter_credit_round_robin_scheduler.sv | 264 ++++++++++++++++++++++++++
 tb/tb_arbiter_credit_round_robin_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_credit_round_robin_scheduler.sv
// -----------------------------------------------------------------------------
// arbiter_credit_round_robin_scheduler
//
// Credit-based round-robin scheduler that shares one cache request path among
// NUM_REQUESTOR engine requesters. Each requester may have at most MAX_CREDIT
// unreturned cache requests in flight. Grants are one-hot, one-cycle pulses
// registered one cycle after eligibility is sampled.
//
// Ports:
//   ap_clk            clock
//   areset            asynchronous, active-high reset
//   arbiter_enable    kernel descriptor valid; scheduling allowed
//   req_in            per-requester pending packet (input FIFO non-empty)
//   downstream_ready  cache request FIFO can accept
//   credit_return_in  per-requester response returned (one credit each)
//   grant_out         one-hot grant pulse (drives FIFO pop / mux select)
//   grant_valid_out   OR of grant_out
//   grant_index_out   index of granted requester, holds when no grant
//   credit_avail_out  per-requester outstanding < MAX_CREDIT
//   idle_out          scheduler in IDLE state
//   error_out         sticky: credit returned with zero outstanding
//
// Optional feature macro: ARBITER_BURST_LOCK_EN
//   When defined, a granted requester keeps winning while eligible for up to
//   MAX_BURST consecutive grants. When undefined, pure round-robin.
// -----------------------------------------------------------------------------
module arbiter_credit_round_robin_scheduler #(
  parameter int NUM_REQUESTOR = 4,
  parameter int MAX_CREDIT    = 8,
  parameter int CREDIT_WIDTH  = 4,
  parameter int MAX_BURST     = 4
) (
  input  logic                             ap_clk,
  input  logic                             areset,
  input  logic                             arbiter_enable,
  input  logic [NUM_REQUESTOR-1:0]         req_in,
  input  logic                             downstream_ready,
  input  logic [NUM_REQUESTOR-1:0]         credit_return_in,
  output logic [NUM_REQUESTOR-1:0]         grant_out,
  output logic                             grant_valid_out,
  output logic [$clog2(NUM_REQUESTOR)-1:0] grant_index_out,
  output logic [NUM_REQUESTOR-1:0]         credit_avail_out,
  output logic                             idle_out,
  output logic                             error_out
);

  localparam int IDX_W = $clog2(NUM_REQUESTOR);

  localparam logic [CREDIT_WIDTH-1:0]  MAX_C    = CREDIT_WIDTH'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0]  ONE_C    = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CREDIT_WIDTH-1:0]  ZERO_C   = {CREDIT_WIDTH{1'b0}};
  localparam logic [NUM_REQUESTOR-1:0] ONE_HOT0 = {{(NUM_REQUESTOR-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQUESTOR-1:0] ZERO_N   = {NUM_REQUESTOR{1'b0}};

  // Reject configurations that cannot work at elaboration time.
  if (NUM_REQUESTOR < 2 || MAX_CREDIT < 1 || MAX_BURST < 1 ||
      (2 ** CREDIT_WIDTH) <= MAX_CREDIT) begin : g_bad_params
    $error("arbiter_credit_round_robin_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Round-robin search: first set bit of mask after ptr, wrapping.
  // Result MSB is the found flag, low bits the index.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQUESTOR-1:0] mask,
                                             input logic [IDX_W-1:0]         ptr);
    logic [IDX_W:0] res;
    int             cand;
    res  = {(IDX_W+1){1'b0}};
    cand = 0;
    for (int k = 1; k <= NUM_REQUESTOR; k++) begin
      cand = (int'(ptr) + k) % NUM_REQUESTOR;
      if (!res[IDX_W] && mask[IDX_W'(cand)]) begin
        res = {1'b1, IDX_W'(cand)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t                    state_q, state_d;
  logic [CREDIT_WIDTH-1:0]   out_q [NUM_REQUESTOR];
  logic [CREDIT_WIDTH-1:0]   out_d [NUM_REQUESTOR];
  logic [NUM_REQUESTOR-1:0]  grant_q, grant_d;
  logic                      grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]          grant_index_q, grant_index_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQUESTOR-1:0]  credit_avail_q, credit_avail_d;
  logic                      idle_q, idle_d;
  logic                      error_q, error_d;

  logic [NUM_REQUESTOR-1:0]  elig;
  logic                      win_found;
  logic [IDX_W-1:0]          win_idx;
  logic                      any_out_d;

`ifdef ARBITER_BURST_LOCK_EN
  localparam int                BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] MAX_B  = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] ONE_B  = {{(BURST_W-1){1'b0}}, 1'b1};
  logic [BURST_W-1:0]           burst_cnt_q, burst_cnt_d;
  logic                         burst_active_q, burst_active_d;
`endif

  // Per-requester eligibility from state, request, backpressure and credit.
  always_comb begin
    elig = ZERO_N;
    for (int i = 0; i < NUM_REQUESTOR; i++) begin
      elig[i] = (state_q == ST_RUN) && req_in[i] && downstream_ready && (out_q[i] < MAX_C);
    end
  end

  // Winner selection: burst lock (if built in) first, else round-robin search.
  always_comb begin
    logic [IDX_W:0] pick;
    pick      = rr_pick(elig, rr_ptr_q);
    win_found = pick[IDX_W];
    win_idx   = pick[IDX_W-1:0];
`ifdef ARBITER_BURST_LOCK_EN
    // rr_ptr_q is the last granted requester, i.e. the current burst owner.
    if (burst_active_q && elig[rr_ptr_q] && (burst_cnt_q < MAX_B)) begin
      win_found = 1'b1;
      win_idx   = rr_ptr_q;
    end else begin
      win_found = pick[IDX_W];
      win_idx   = pick[IDX_W-1:0];
    end
`endif
  end

  // Grant outputs, pointer, credit counters and sticky error next-state.
  always_comb begin
    grant_d        = ZERO_N;
    grant_valid_d  = win_found;
    grant_index_d  = grant_index_q;
    rr_ptr_d       = rr_ptr_q;
    error_d        = error_q;
    any_out_d      = 1'b0;
    credit_avail_d = ZERO_N;
    if (win_found) begin
      grant_d       = ONE_HOT0 << win_idx;
      grant_index_d = win_idx;
      rr_ptr_d      = win_idx;
    end else begin
      grant_d       = ZERO_N;
    end
    // Counters track the decided grant so credit_avail matches grant_out.
    for (int i = 0; i < NUM_REQUESTOR; i++) begin
      out_d[i] = out_q[i];
      case ({grant_d[i], credit_return_in[i]})
        2'b10: begin
          if (out_q[i] < MAX_C) begin
            out_d[i] = out_q[i] + ONE_C;
          end else begin
            out_d[i] = out_q[i];
          end
        end
        2'b01: begin
          if (out_q[i] == ZERO_C) begin
            error_d  = 1'b1;
            out_d[i] = ZERO_C;
          end else begin
            out_d[i] = out_q[i] - ONE_C;
          end
        end
        default: out_d[i] = out_q[i];
      endcase
      credit_avail_d[i] = (out_d[i] < MAX_C);
      any_out_d         = any_out_d | (out_d[i] != ZERO_C);
    end
  end

  // FSM next state; drain waits on next-cycle outstanding so a final grant is counted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arbiter_enable) state_d = ST_RUN;
        else                state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (arbiter_enable) state_d = ST_RUN;
        else if (any_out_d) state_d = ST_DRAIN;
        else                state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (arbiter_enable)  state_d = ST_RUN;
        else if (any_out_d)  state_d = ST_DRAIN;
        else                 state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

`ifdef ARBITER_BURST_LOCK_EN
  // Burst length tracking; any cycle without a grant ends the burst.
  always_comb begin
    burst_cnt_d    = burst_cnt_q;
    burst_active_d = burst_active_q;
    if (win_found) begin
      burst_active_d = 1'b1;
      if (burst_active_q && (win_idx == rr_ptr_q) && (burst_cnt_q < MAX_B)) begin
        burst_cnt_d = burst_cnt_q + ONE_B;
      end else begin
        burst_cnt_d = ONE_B;
      end
    end else begin
      burst_active_d = 1'b0;
      burst_cnt_d    = {BURST_W{1'b0}};
    end
  end
`endif

  // State, counters and registered outputs.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q        <= ST_IDLE;
      grant_q        <= ZERO_N;
      grant_valid_q  <= 1'b0;
      grant_index_q  <= {IDX_W{1'b0}};
      rr_ptr_q       <= IDX_W'(NUM_REQUESTOR - 1);
      credit_avail_q <= {NUM_REQUESTOR{1'b1}};
      idle_q         <= 1'b1;
      error_q        <= 1'b0;
      for (int i = 0; i < NUM_REQUESTOR; i++) begin
        out_q[i] <= ZERO_C;
      end
`ifdef ARBITER_BURST_LOCK_EN
      burst_cnt_q    <= {BURST_W{1'b0}};
      burst_active_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_valid_q  <= grant_valid_d;
      grant_index_q  <= grant_index_d;
      rr_ptr_q       <= rr_ptr_d;
      credit_avail_q <= credit_avail_d;
      idle_q         <= idle_d;
      error_q        <= error_d;
      for (int i = 0; i < NUM_REQUESTOR; i++) begin
        out_q[i] <= out_d[i];
      end
`ifdef ARBITER_BURST_LOCK_EN
      burst_cnt_q    <= burst_cnt_d;
      burst_active_q <= burst_active_d;
`endif
    end
  end

  assign grant_out        = grant_q;
  assign grant_valid_out  = grant_valid_q;
  assign grant_index_out  = grant_index_q;
  assign credit_avail_out = credit_avail_q;
  assign idle_out         = idle_q;
  assign error_out        = error_q;

endmodule

// File: tb/tb_arbiter_credit_round_robin_scheduler.sv
// Testbench for arbiter_credit_round_robin_scheduler (default parameters).
module tb_arbiter_credit_round_robin_scheduler;

  logic       ap_clk;
  logic       areset;
  logic       arbiter_enable;
  logic [3:0] req_in;
  logic       downstream_ready;
  logic [3:0] credit_return_in;
  logic [3:0] grant_out;
  logic       grant_valid_out;
  logic [1:0] grant_index_out;
  logic [3:0] credit_avail_out;
  logic       idle_out;
  logic       error_out;

  int errors = 0;
  int checks = 0;
  int sb_q[$];

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] ret;
    logic       exp_valid;
    logic [1:0] exp_idx;
    logic       exp_idle;
  } vec_t;

  vec_t tbl[16];

  arbiter_credit_round_robin_scheduler dut (
    .ap_clk           (ap_clk),
    .areset           (areset),
    .arbiter_enable   (arbiter_enable),
    .req_in           (req_in),
    .downstream_ready (downstream_ready),
    .credit_return_in (credit_return_in),
    .grant_out        (grant_out),
    .grant_valid_out  (grant_valid_out),
    .grant_index_out  (grant_index_out),
    .credit_avail_out (credit_avail_out),
    .idle_out         (idle_out),
    .error_out        (error_out)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, grants scored against the queue.
  task automatic tick();
    int e;
    @(posedge ap_clk);
    #1;
    if (grant_valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_grant: got index %0d expected no grant", grant_index_out);
      end else begin
        e = sb_q.pop_front();
        check("sb_grant_index", grant_index_out, e);
        check("sb_grant_onehot", grant_out, 32'd1 << e);
      end
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] req, input logic rdy, input logic [3:0] ret);
    arbiter_enable   = en;
    req_in           = req;
    downstream_ready = rdy;
    credit_return_in = ret;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    areset = 1'b1;
    @(posedge ap_clk);
    #1;
    areset = 1'b0;
    sb_q.delete();
  endtask

  function automatic vec_t mk(input logic en, input logic [3:0] req, input logic rdy,
                              input logic [3:0] ret, input logic v, input logic [1:0] idx,
                              input logic idle);
    vec_t r;
    r.en = en; r.req = req; r.rdy = rdy; r.ret = ret;
    r.exp_valid = v; r.exp_idx = idx; r.exp_idle = idle;
    return r;
  endfunction

  initial begin
    // Sparse requests, late requester 1, then backpressure with all requesting.
    tbl[0]  = mk(1'b1, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
    tbl[1]  = mk(1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
    tbl[2]  = mk(1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    tbl[3]  = mk(1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
    tbl[4]  = mk(1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    tbl[5]  = mk(1'b1, 4'b0110, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0);
    tbl[6]  = mk(1'b1, 4'b0110, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    tbl[7]  = mk(1'b1, 4'b0110, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0);
    tbl[8]  = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
    tbl[9]  = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
    tbl[10] = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
    tbl[11] = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
    tbl[12] = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
    tbl[13] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    tbl[14] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0);
    tbl[15] = mk(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);

    areset = 1'b1;
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    repeat (2) @(posedge ap_clk);
    #1;
    // Reset state.
    check("rst_grant", grant_out, 4'b0000);
    check("rst_valid", grant_valid_out, 1'b0);
    check("rst_index", grant_index_out, 2'd0);
    check("rst_avail", credit_avail_out, 4'b1111);
    check("rst_idle", idle_out, 1'b1);
    check("rst_error", error_out, 1'b0);
    areset = 1'b0;

    // Round-robin until every requester has exhausted its credit.
    do_reset();
    drive(1'b1, 4'b1111, 1'b1, 4'b0000);
    tick();
    check("t1_idle_run", idle_out, 1'b0);
    check("t1_first_valid", grant_valid_out, 1'b0);
    for (int g = 0; g < 32; g++) begin
      sb_q.push_back(g % 4);
      tick();
    end
    check("t1_avail_exhausted", credit_avail_out, 4'b0000);
    tick();
    check("t1_no_grant", grant_valid_out, 1'b0);
    check("t1_sb_drain", sb_q.size(), 0);

    // Table: sparse requests and backpressure.
    do_reset();
    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].en, tbl[r].req, tbl[r].rdy, tbl[r].ret);
      if (tbl[r].exp_valid) sb_q.push_back(int'(tbl[r].exp_idx));
      tick();
      check("tbl_valid", grant_valid_out, tbl[r].exp_valid);
      check("tbl_index", grant_index_out, tbl[r].exp_idx);
      check("tbl_idle", idle_out, tbl[r].exp_idle);
    end
    check("tbl_sb_drain", sb_q.size(), 0);

    // Simultaneous grant+return keeps the count; return at zero sets sticky error.
    do_reset();
    drive(1'b1, 4'b0000, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 4'b0010, 1'b1, 4'b0000);
    repeat (3) begin sb_q.push_back(1); tick(); end
    drive(1'b1, 4'b0010, 1'b1, 4'b0010);
    sb_q.push_back(1);
    tick();
    drive(1'b1, 4'b0010, 1'b1, 4'b0000);
    repeat (4) begin sb_q.push_back(1); tick(); end
    check("t4_avail1_at7", credit_avail_out[1], 1'b1);
    sb_q.push_back(1);
    tick();
    check("t4_avail1_at8", credit_avail_out[1], 1'b0);
    tick();
    check("t4_no_grant_full", grant_valid_out, 1'b0);
    drive(1'b1, 4'b0000, 1'b1, 4'b0100);
    tick();
    check("t4_error_set", error_out, 1'b1);
    drive(1'b1, 4'b0100, 1'b1, 4'b0000);
    repeat (7) begin sb_q.push_back(2); tick(); end
    check("t4_avail2_at7", credit_avail_out[2], 1'b1);
    sb_q.push_back(2);
    tick();
    check("t4_avail2_at8", credit_avail_out[2], 1'b0);
    drive(1'b1, 4'b0000, 1'b1, 4'b0000);
    repeat (3) tick();
    check("t4_error_sticky", error_out, 1'b1);
    check("t4_sb_drain", sb_q.size(), 0);

    // Drain: enable drops with requester 3 in flight.
    do_reset();
    drive(1'b1, 4'b0000, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 4'b1000, 1'b1, 4'b0000);
    sb_q.push_back(3);
    tick();
    drive(1'b0, 4'b1000, 1'b1, 4'b0000);
    sb_q.push_back(3);
    tick();
    check("t5_drain_idle", idle_out, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_drain_no_grant", grant_valid_out, 1'b0);
      check("t5_drain_idle_hold", idle_out, 1'b0);
    end
    drive(1'b0, 4'b1000, 1'b1, 4'b1000);
    tick();
    check("t5_one_left", idle_out, 1'b0);
    tick();
    check("t5_back_idle", idle_out, 1'b1);
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    check("t5_no_error", error_out, 1'b0);
    check("t5_sb_drain", sb_q.size(), 0);

    // Asynchronous reset between edges.
    drive(1'b1, 4'b0100, 1'b1, 4'b0001);
    tick();
    drive(1'b1, 4'b0100, 1'b1, 4'b0000);
    sb_q.push_back(2);
    tick();
    check("t5_pre_error", error_out, 1'b1);
    check("t5_pre_valid", grant_valid_out, 1'b1);
    #3;
    areset = 1'b1;
    #1;
    check("async_grant", grant_out, 4'b0000);
    check("async_valid", grant_valid_out, 1'b0);
    check("async_index", grant_index_out, 2'd0);
    check("async_avail", credit_avail_out, 4'b1111);
    check("async_idle", idle_out, 1'b1);
    check("async_error", error_out, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 4'b0000);
    #2;
    areset = 1'b0;
    sb_q.delete();

    // Grant order with all requesting and ample credit.
    begin
      int exp_seq[9];
`ifdef ARBITER_BURST_LOCK_EN
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
`else
      exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
`endif
      do_reset();
      drive(1'b1, 4'b1111, 1'b1, 4'b0000);
      tick();
      for (int g = 0; g < 9; g++) begin
        sb_q.push_back(exp_seq[g]);
        tick();
        check("t6_valid", grant_valid_out, 1'b1);
      end
      check("t6_sb_drain", sb_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
